// File: rtl/secded_decoder_pkg.sv
// secded_decoder_pkg: shared definitions for the Hamming(16,11) SECDED decode engine.
//   - state_e       : decode FSM states
//   - F_*           : 2-bit per-word status codes written to the output high byte
//   - POS_*         : codeword bit positions (bit i = Hamming position i, bit 0 = overall parity)
//   - extract_data  : pulls the 11 data bits out of a 16-bit codeword
package secded_decoder_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetchLo,
      StFetchHi,
      StDecode,
      StWrLo,
      StWrHi,
      StDone
   } state_e;

   localparam logic [1:0] F_CLEAN  = 2'b00;
   localparam logic [1:0] F_SINGLE = 2'b01;
   localparam logic [1:0] F_DOUBLE = 2'b10;

   // Parity bits sit at the power-of-two positions; p0 covers the whole word.
   localparam int unsigned POS_P0 = 0;
   localparam int unsigned POS_P1 = 1;
   localparam int unsigned POS_P2 = 2;
   localparam int unsigned POS_D0 = 3;
   localparam int unsigned POS_P4 = 4;
   localparam int unsigned POS_D1 = 5;
   localparam int unsigned POS_D2 = 6;
   localparam int unsigned POS_D3 = 7;
   localparam int unsigned POS_P8 = 8;
   localparam int unsigned POS_D4 = 9;

   // d[10:4] occupy positions 15..9 contiguously; d[3:0] are scattered in the low byte.
   function automatic logic [10:0] extract_data(input logic [15:0] cw);
      return {cw[15:POS_D4], cw[POS_D3], cw[POS_D2], cw[POS_D1], cw[POS_D0]};
   endfunction

endpackage

// File: rtl/secded_decoder_if.sv
// secded_decoder_if: byte-wide data-memory port used by the decode engine.
//   MemAddr   : byte address (AW bits), driven by master
//   MemWrEn   : write strobe, driven by master
//   MemWrData : write data, driven by master
//   MemRdData : read data, driven by memory one cycle after MemAddr
interface secded_decoder_if #(
   parameter int unsigned AW = 8
);
   logic [AW-1:0] MemAddr;
   logic          MemWrEn;
   logic [7:0]    MemWrData;
   logic [7:0]    MemRdData;

   modport master (
      output MemAddr,
      output MemWrEn,
      output MemWrData,
      input  MemRdData
   );

   modport slave (
      input  MemAddr,
      input  MemWrEn,
      input  MemWrData,
      output MemRdData
   );
endinterface

// File: rtl/secded_syndrome.sv
// secded_syndrome: combinational Hamming(16,11) SECDED check of one codeword.
//   cw_i   : 16-bit codeword {high byte, low byte}
//   data_o : 11-bit data, corrected when a single error is seen
//   syn_o  : syndrome s (XOR of the positions of all set bits 1..15)
//   g_o    : overall parity (XOR of all 16 bits)
//   f_o    : status F_CLEAN / F_SINGLE / F_DOUBLE
module secded_syndrome
   import secded_decoder_pkg::*;
(
   input  logic [15:0] cw_i,
   output logic [10:0] data_o,
   output logic [3:0]  syn_o,
   output logic        g_o,
   output logic [1:0]  f_o
);

   logic [3:0]  syn;
   logic        g;
   logic [15:0] fixed;

   always_comb begin
      syn = '0;
      for (int unsigned i = 1; i < 16; i++) begin
         if (cw_i[i]) syn = syn ^ 4'(i);
      end
      g = ^cw_i;

      // Odd parity means one flipped bit at position s; s==0 is p0 itself.
      fixed = cw_i;
      if (g) fixed = cw_i ^ (16'h0001 << syn);

      if (g)              f_o = F_SINGLE;
      else if (syn != '0) f_o = F_DOUBLE;
      else                f_o = F_CLEAN;

      data_o = extract_data(fixed);
      syn_o  = syn;
      g_o    = g;
   end

endmodule

// File: rtl/secded_decoder.sv
// secded_decoder: sequential SECDED decode engine acting as a data-memory master.
// On Start (sampled in idle) it reads NUM_WORDS codewords as byte pairs from SRC_BASE,
// decodes each, and writes {data[7:0]} and {F,3'b000,data[10:8]} to DST_BASE; then Done.
//   Clk, Reset : clock and synchronous active-high reset
//   Start      : level run request, only seen in idle
//   mem        : memory port (secded_decoder_if.master)
//   Done       : held high after a run until Start drops
//   SglCount   : corrected-word count of the current run (saturating)
//   DblCount   : double-error word count of the current run (saturating)
// Build option SECDED_DEC_STATS_EN: when undefined, the counters are omitted and tied to 0.
module secded_decoder
   import secded_decoder_pkg::*;
#(
   parameter int unsigned NUM_WORDS = 15,
   parameter int unsigned SRC_BASE  = 0,
   parameter int unsigned DST_BASE  = 30,
   parameter int unsigned AW        = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   secded_decoder_if.master  mem,
   output logic              Done,
   output logic [7:0]        SglCount,
   output logic [7:0]        DblCount
);

   localparam logic [6:0]    LastK   = 7'(NUM_WORDS - 1);
   localparam logic [AW-1:0] SrcBase = AW'(SRC_BASE);
   localparam logic [AW-1:0] DstBase = AW'(DST_BASE);

   state_e        state_q;
   logic [6:0]    k_q;
   logic [7:0]    lo_q;
   logic [2:0]    data_hi_q;
   logic [1:0]    f_q;
   logic [AW-1:0] addr_q;
   logic          wr_en_q;
   logic [7:0]    wr_data_q;
   logic          done_q;

   logic [10:0]   syn_data;
   logic [3:0]    syn_s;
   logic          syn_g;
   logic [1:0]    syn_f;
   logic          unused_syn;

   // Address arithmetic is kept at AW bits so it wraps modulo 2^AW.
   logic [AW-1:0] src_lo, dst_lo;
   assign src_lo = SrcBase + AW'({k_q, 1'b0});
   assign dst_lo = DstBase + AW'({k_q, 1'b0});

   // High byte comes straight off the read port during DECODE.
   secded_syndrome u_syndrome (
      .cw_i   ({mem.MemRdData, lo_q}),
      .data_o (syn_data),
      .syn_o  (syn_s),
      .g_o    (syn_g),
      .f_o    (syn_f)
   );

   assign unused_syn = ^{syn_s, syn_g};

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= StIdle;
         k_q       <= '0;
         lo_q      <= '0;
         data_hi_q <= '0;
         f_q       <= F_CLEAN;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               wr_en_q <= 1'b0;
               done_q  <= 1'b0;
               if (Start) begin
                  k_q     <= '0;
                  addr_q  <= SrcBase;
                  state_q <= StFetchLo;
               end
            end
            StFetchLo: begin
               addr_q  <= src_lo + AW'(1);
               state_q <= StFetchHi;
            end
            StFetchHi: begin
               lo_q    <= mem.MemRdData;
               state_q <= StDecode;
            end
            StDecode: begin
               data_hi_q <= syn_data[10:8];
               f_q       <= syn_f;
               addr_q    <= dst_lo;
               wr_en_q   <= 1'b1;
               wr_data_q <= syn_data[7:0];
               state_q   <= StWrLo;
            end
            StWrLo: begin
               addr_q    <= dst_lo + AW'(1);
               wr_data_q <= {f_q, 3'b000, data_hi_q};
               state_q   <= StWrHi;
            end
            StWrHi: begin
               wr_en_q <= 1'b0;
               k_q     <= k_q + 7'd1;
               if (k_q == LastK) begin
                  state_q <= StDone;
               end else begin
                  addr_q  <= src_lo + AW'(2);
                  state_q <= StFetchLo;
               end
            end
            StDone: begin
               // Done is guaranteed at least one cycle before Start low releases it.
               if (done_q && !Start) begin
                  done_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  done_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mem.MemAddr   = addr_q;
   assign mem.MemWrEn   = wr_en_q;
   assign mem.MemWrData = wr_data_q;
   assign Done          = done_q;

`ifdef SECDED_DEC_STATS_EN
   logic [7:0] sgl_q, dbl_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sgl_q <= '0;
         dbl_q <= '0;
      end else if (state_q == StIdle && Start) begin
         sgl_q <= '0;
         dbl_q <= '0;
      end else if (state_q == StDecode) begin
         if (syn_f == F_SINGLE && sgl_q != 8'hFF) sgl_q <= sgl_q + 8'd1;
         if (syn_f == F_DOUBLE && dbl_q != 8'hFF) dbl_q <= dbl_q + 8'd1;
      end
   end

   assign SglCount = sgl_q;
   assign DblCount = dbl_q;
`else
   assign SglCount = '0;
   assign DblCount = '0;
`endif

endmodule

// File: tb/tb_secded_decoder.sv
// tb_secded_decoder: scoreboard bench for secded_decoder. Directed codewords with
// hand-derived outputs are preloaded; expected writes are queued per run and a
// negedge monitor pops and compares every MemWrEn beat.
module tb_secded_decoder;
   import secded_decoder_pkg::*;

   localparam int unsigned NW  = 15;
   localparam int unsigned DST = 30;
   localparam int unsigned AW  = 8;

`ifdef SECDED_DEC_STATS_EN
   localparam int unsigned EXP_SGL = 6;
   localparam int unsigned EXP_DBL = 4;
`else
   localparam int unsigned EXP_SGL = 0;
   localparam int unsigned EXP_DBL = 0;
`endif

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic       Done;
   logic [7:0] SglCount;
   logic [7:0] DblCount;

   secded_decoder_if #(.AW(AW)) bus ();

   secded_decoder #(
      .NUM_WORDS (NW),
      .SRC_BASE  (0),
      .DST_BASE  (DST),
      .AW        (AW)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .mem      (bus.master),
      .Done     (Done),
      .SglCount (SglCount),
      .DblCount (DblCount)
   );

   always #5 Clk = ~Clk;

   // Codeword k: lo/hi at bytes 2k/2k+1. Expected output bytes hand-derived.
   logic [7:0] vec_lo [NW] = '{8'hFF, 8'h20, 8'h01, 8'h08, 8'h00, 8'h0F, 8'h07, 8'h03,
                               8'h03, 8'h09, 8'hFF, 8'hFE, 8'hFF, 8'h17, 8'h77};
   logic [7:0] vec_hi [NW] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03,
                               8'h83, 8'h00, 8'hFE, 8'h7F, 8'h7F, 8'h81, 8'h81};
   logic [7:0] exp_lo [NW] = '{8'hFF, 8'h00, 8'h00, 8'h11, 8'h00, 8'h01, 8'h01, 8'h10,
                               8'h10, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h06};
   logic [7:0] exp_hi [NW] = '{8'h07, 8'h40, 8'h40, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00,
                               8'h40, 8'h80, 8'h47, 8'h83, 8'h47, 8'h04, 8'h84};

   logic [7:0] mem [256];

   always @(posedge Clk) begin
      if (bus.MemWrEn === 1'b1) mem[bus.MemAddr] <= bus.MemWrData;
      bus.MemRdData <= mem[bus.MemAddr];
   end

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t exp_q [$];
   int  total   = 0;
   int  bad     = 0;
   int  strobes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_run(input int unsigned nwords);
      for (int unsigned k = 0; k < nwords; k++) begin
         exp_q.push_back('{addr: 8'(DST + 2 * k),     data: exp_lo[k]});
         exp_q.push_back('{addr: 8'(DST + 2 * k + 1), data: exp_hi[k]});
      end
   endtask

   // Monitor: every write beat must match the head of the scoreboard.
   always @(negedge Clk) begin
      if (bus.MemWrEn === 1'b1) begin
         wr_t e;
         strobes++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                     bus.MemAddr, bus.MemWrData);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(bus.MemAddr), 32'(e.addr));
            check("wr_data", 32'(bus.MemWrData), 32'(e.data));
         end
      end
   end

   task automatic run_full(input string tag);
      int cyc;
      int base;
      bit found;
      push_run(NW);
      base = strobes;
      @(negedge Clk);
      Start = 1'b1;
      @(posedge Clk);  // edge that samples Start in idle
      cyc   = 0;
      found = 1'b0;
      while (cyc < 200 && !found) begin
         @(posedge Clk);
         cyc++;
         #1;
         if (Done === 1'b1) found = 1'b1;
      end
      check({tag, "_done_cycle"}, 32'(cyc), 32'd76);
      repeat (3) @(negedge Clk);
      check({tag, "_done_hold"}, 32'(Done), 32'd1);
      check({tag, "_sgl_count"}, 32'(SglCount), 32'(EXP_SGL));
      check({tag, "_dbl_count"}, 32'(DblCount), 32'(EXP_DBL));
      check({tag, "_strobes"}, 32'(strobes - base), 32'd30);
      check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
      Start = 1'b0;
      @(posedge Clk);
      #1;
      check({tag, "_done_release"}, 32'(Done), 32'd0);
      repeat (5) @(negedge Clk);
      check({tag, "_idle_no_write"}, 32'(strobes - base), 32'd30);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
      for (int k = 0; k < int'(NW); k++) begin
         mem[2 * k]     = vec_lo[k];
         mem[2 * k + 1] = vec_hi[k];
      end
      Reset = 1'b1;
      Start = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("rst_addr",  32'(bus.MemAddr), 32'd0);
      check("rst_wren",  32'(bus.MemWrEn), 32'd0);
      check("rst_wdata", 32'(bus.MemWrData), 32'd0);
      check("rst_done",  32'(Done), 32'd0);
      check("rst_sgl",   32'(SglCount), 32'd0);
      check("rst_dbl",   32'(DblCount), 32'd0);
      Reset = 1'b0;

      run_full("run1");
      check("mem_last_hi", 32'(mem[DST + 29]), 32'(exp_hi[NW - 1]));
      check("mem_no_overrun", 32'(mem[DST + 30]), 32'hA5);

      // Reset lands on edge 12 of a run: words 0 and 1 already written, word 2 not.
      push_run(2);
      base = strobes;
      @(negedge Clk);
      Start = 1'b1;
      @(posedge Clk);
      repeat (11) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      Start = 1'b0;
      @(posedge Clk);
      #1;
      check("midrst_addr",  32'(bus.MemAddr), 32'd0);
      check("midrst_wren",  32'(bus.MemWrEn), 32'd0);
      check("midrst_wdata", 32'(bus.MemWrData), 32'd0);
      check("midrst_done",  32'(Done), 32'd0);
      check("midrst_sgl",   32'(SglCount), 32'd0);
      check("midrst_dbl",   32'(DblCount), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (20) @(negedge Clk);
      check("midrst_strobes", 32'(strobes - base), 32'd4);
      check("midrst_queue_left", 32'(exp_q.size()), 32'd0);

      run_full("rerun");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/secded_decoder.md
# secded_decoder

Sequential Hamming(16,11) SECDED decode engine, the receiving end of the ALU's MSB_ECC/LSB_ECC encode path. On Start it walks a block of 16-bit codewords stored as byte pairs in data memory. For each codeword it computes the syndrome and overall parity, corrects single-bit errors and flags double-bit errors. It writes the 11-bit data plus a 2-bit status to a destination block, then raises Done. It sits beside the CPU core as a memory-port master.

## Interface
- NUM_WORDS, 15: codewords processed per run, 1..127.
- SRC_BASE, 0: byte address of the first codeword's low byte.
- DST_BASE, 30: byte address of the first output low byte.
- AW, 8: memory address width.
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  level request; sampled in IDLE only.
- MemRdData  in  8  read data; valid one cycle after MemAddr is driven.
- MemAddr  out  AW  byte address.
- MemWrEn  out  1  write strobe.
- MemWrData  out  8  write data.
- Done  out  1  run complete.
- SglCount  out  8  corrected-word count.
- DblCount  out  8  double-error word count.

## Operation
- Codeword layout. Low byte = {d3,d2,d1,p4,d0,p2,p1,p0}; high byte = {d10..d4,p8}.
  - Codeword bit i (1..15) is Hamming position i; bit 0 is overall parity p0.
- Decode, per word:
  - s[3:0] = XOR of all positions i in 1..15 whose bit is 1.
  - g = XOR of all 16 bits.
- Status:
  - g=0, s=0 → F=00, data as read.
  - g=1 → F=01; flip bit s (s=0 means p0 itself flipped).
  - g=0, s≠0 → F=10; data extracted uncorrected.
- Output pair for word k:
  - DST_BASE+2k = d[7:0].
  - DST_BASE+2k+1 = {F[1:0],3'b000,d[10:8]}.
- FSM states: IDLE → FETCH_LO → FETCH_HI → DECODE → WR_LO → WR_HI → (k==NUM_WORDS-1 ? DONE : FETCH_LO).
  - FETCH_LO drives SRC_BASE+2k.
  - FETCH_HI drives SRC_BASE+2k+1 and captures the low byte.
  - DECODE captures the high byte, computes and registers d and F, and updates the counters.
  - WR_LO and WR_HI assert MemWrEn with the output bytes; k increments in WR_HI.
  - DONE holds Done=1 until Start is seen low, then → IDLE.
- Start high while not in IDLE is ignored.
- A new run clears k and both counters when leaving IDLE.
- Address arithmetic is modulo 2^AW (wraps silently).
- Counters saturate at 255.

## Timing
- Reset values: state IDLE, MemAddr 0, MemWrEn 0, MemWrData 0, Done 0, counters 0, k 0.
- Reset mid-run: IDLE on the next edge. No further writes; partial output is left in memory.
- 5 cycles per word.
- Done rises 5·NUM_WORDS+1 edges after the edge that samples Start in IDLE. That is 76 cycles for NUM_WORDS=15.
- MemWrEn is high exactly 2 cycles per word and never in FETCH or DECODE states.

## Configuration
- SECDED_DEC_STATS_EN
  - Defined: SglCount and DblCount count F=01 and F=10 words of the current run. Their values hold after Done.
  - Undefined: the counter registers are not built, and both ports are tied to 0.
- Decode and write behaviour are identical either way.

## Structure
- Shared package definitions:
  - FSM state enum.
  - Status constants: F_CLEAN=2'b00, F_SINGLE=2'b01, F_DOUBLE=2'b10.
  - Codeword bit-position constants.
- One combinational sub-module, secded_syndrome: 16-bit codeword in; 11-bit data, s, g and F out.
  - Reusable by the bench as a reference model.

## Test plan
- Codeword 0xFFFF (data 0x7FF) → writes 0xFF, 0x07; SglCount 0, DblCount 0.
- Codeword 0x0000 with bit 5 flipped (lo 0x20, hi 0x00) → writes 0x00, 0x40; SglCount 1.
- lo 0x01, hi 0x00 (p0 flipped) → writes 0x00, 0x40.
- lo 0x08, hi 0x02 (bits 3 and 9 flipped) → writes 0x11, 0x80; DblCount 1.
- NUM_WORDS=15, Start held high:
  - Done rises at cycle 76 and stays high while Start is high.
  - Dropping Start returns to IDLE.
  - Exactly 30 write strobes occur at addresses 30..59.
- Reset asserted in cycle 12 of a run:
  - All outputs return to reset values on the next edge.
  - No MemWrEn afterwards.
  - A fresh Start completes normally.
